mlp_dot_sequencer: RTL and testbench
====================================

MLP_DOT_SEQUENCER -- requirements
Module: mlp_dot_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SIZE, 4, elements per chunk
  DATA_WIDTH, 16, signed fixed-point width
  FRACTION_WIDTH, 8, fractional bits
  NUM_CHUNKS, 3, chunks per neuron (>=1)
  RELU_EN, 1, apply ReLU to final result
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  begin one neuron evaluation
  busy  out  1  high from start acceptance until out handshake completes
  chunk_req  out  1  one-cycle fetch request to operand memory
  chunk_idx  out  $clog2(NUM_CHUNKS) (min 1)  chunk address
  chunk_valid  in  1  operands valid this cycle
  chunk_data  in  SIZE x DATA_WIDTH signed  input chunk
  chunk_weights  in  SIZE x DATA_WIDTH signed  weight chunk
  bias  in  DATA_WIDTH signed  neuron bias, sampled at start
  dot_reset  out  1  synchronous active-high accumulator clear to downstream dot stage
  dot_run  out  1  run to downstream dot stage
  dot_data, dot_weights  out  SIZE x DATA_WIDTH signed  registered operands
  dot_bias  out  DATA_WIDTH signed  bias for current chunk
  dot_finished  in  1  downstream finished level
  dot_result  in  DATA_WIDTH signed  downstream accumulated result
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts result
  out_data  out  DATA_WIDTH signed  final neuron output

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, FETCH, WAIT_DATA, RUN, ACCUM, WAIT_LOW, OUTPUT.
REQ-004 IDLE: start=1 -> CLEAR; capture bias; chunk counter <= 0; busy <= 1.
REQ-005 CLEAR: dot_reset=1 for exactly one cycle -> FETCH.
REQ-006 FETCH: chunk_req=1 for one cycle with chunk_idx=counter -> WAIT_DATA.
REQ-007 WAIT_DATA: on chunk_valid=1, register chunk_data/chunk_weights onto dot_data/dot_weights -> RUN; wait indefinitely otherwise.
REQ-008 RUN: dot_run=1; on rising edge of dot_finished (current 1, previous-cycle 0) -> ACCUM.
REQ-009 ACCUM: dot_run=0 for one cycle, letting downstream accumulator update -> WAIT_LOW.
REQ-010 WAIT_LOW: wait dot_finished=0; then if counter==NUM_CHUNKS-1 -> OUTPUT, else counter+1 -> FETCH.
REQ-011 dot_bias SHALL equal captured bias for chunk 0 and 0 for all other chunks, so bias is added exactly once.
REQ-012 OUTPUT: out_valid=1, out_data = (RELU_EN && dot_result<0) ? 0 : dot_result, registered on entry and stable while out_valid=1; on out_ready=1 -> IDLE, busy=0 next cycle.
REQ-013 out_valid && out_ready in the same cycle SHALL complete the transfer; out_ready while out_valid=0 SHALL be ignored.
REQ-014 start while busy=1 SHALL be ignored; start in the same cycle OUTPUT completes SHALL be ignored (IDLE must be visited).
REQ-015 chunk_valid outside WAIT_DATA SHALL be ignored.
REQ-016 NUM_CHUNKS=1: single pass, chunk_idx always 0, WAIT_LOW -> OUTPUT.
REQ-017 Minimum latency start -> out_valid SHALL be 2 + NUM_CHUNKS*(4 + memory latency + downstream latency) cycles; no combinational path from any input to any output.

Reset
REQ-018 reset=0 SHALL asynchronously force IDLE, counter 0, and all outputs 0 (busy, chunk_req, chunk_idx, dot_reset, dot_run, dot_data, dot_weights, dot_bias, out_valid, out_data).
REQ-019 reset asserted mid-operation SHALL abandon the evaluation; the first post-reset start SHALL pass through CLEAR.

Structure
REQ-020 The FSM state enum typedef SHALL live in shared package mlp_pkg, together with the ReLU helper function.
REQ-021 One sub-module, mlp_rise_detect (registered rising-edge detector for dot_finished), SHALL be instantiated; everything else is flat.

Verification (SIZE=4, DATA_WIDTH=16, FRACTION_WIDTH=8, NUM_CHUNKS=3; behavioural downstream model)
REQ-022 Data all 1.0 (0x0100), weights all 0.5 (0x0080), bias 0.25 (0x0040) -> out_data 0x0640 (6.25), bias applied once, chunk_idx sequence 0,1,2.
REQ-023 Weights all -1.0 (0xFF00), data 1.0, bias 0, RELU_EN=1 -> out_data 0; with RELU_EN=0 -> 0xF400 (-12.0).
REQ-024 chunk_valid delayed 5 cycles per fetch, out_ready held low 10 cycles -> same result, out_data stable, busy high throughout, extra start pulses ignored.
REQ-025 reset pulsed low during RUN of chunk 1 -> all outputs 0 immediately; new start -> dot_reset pulse, correct result 0x0640.
REQ-026 NUM_CHUNKS=1 build, data 2.0 x weights 2.0 x 4, bias 0 -> out_data 0x1000 (16.0); back-to-back evaluations give identical results (accumulator cleared).

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP dot-product sequencer: FSM state encoding
// and the ReLU clamp helper.
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_RUN,
        ST_ACCUM,
        ST_WAIT_LOW,
        ST_OUTPUT
    } mlp_state_e;

    // True when a negative result must be forced to zero.
    function automatic logic relu_clamp(input logic relu_en, input logic sign_bit);
        return relu_en & sign_bit;
    endfunction

endpackage

// File: rtl/mlp_rise_detect.sv
// Rising-edge detector for the downstream dot_finished level; the previous
// sample is held in a flop so a level that stays high fires only once.
module mlp_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/mlp_dot_sequencer.sv
// Sequences one neuron evaluation: fetches NUM_CHUNKS operand chunks, drives a
// downstream dot-product accumulator per chunk and presents the ReLU'd result.
//
// state        | meaning
// IDLE         | waiting for start, busy low
// CLEAR        | one-cycle dot_reset pulse to the downstream accumulator
// FETCH        | one-cycle chunk_req for chunk_idx
// WAIT_DATA    | waiting for chunk_valid, then latch operands
// RUN          | dot_run high until dot_finished rises
// ACCUM        | dot_run low for one cycle so the accumulator updates
// WAIT_LOW     | wait for dot_finished to drop, then next chunk or output
// OUTPUT       | out_valid high until out_ready
module mlp_dot_sequencer
    import mlp_pkg::*;
#(
    parameter int SIZE           = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int FRACTION_WIDTH = 8,
    parameter int NUM_CHUNKS     = 3,
    parameter bit RELU_EN        = 1'b1,
    localparam int IDX_W         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                chunk_req,
    output logic [IDX_W-1:0]                    chunk_idx,
    input  logic                                chunk_valid,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]     chunk_data,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]     chunk_weights,
    input  logic signed [DATA_WIDTH-1:0]        bias,
    output logic                                dot_reset,
    output logic                                dot_run,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]     dot_data,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]     dot_weights,
    output logic signed [DATA_WIDTH-1:0]        dot_bias,
    input  logic                                dot_finished,
    input  logic signed [DATA_WIDTH-1:0]        dot_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [DATA_WIDTH-1:0]        out_data
);

    if (NUM_CHUNKS < 1 || FRACTION_WIDTH >= DATA_WIDTH) begin : g_bad_params
        $error("mlp_dot_sequencer: need NUM_CHUNKS >= 1 and FRACTION_WIDTH < DATA_WIDTH");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    mlp_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0]    bias_q, bias_d;
    logic                            busy_q, busy_d;
    logic                            chunk_req_q, chunk_req_d;
    logic [IDX_W-1:0]                chunk_idx_q, chunk_idx_d;
    logic                            dot_reset_q, dot_reset_d;
    logic                            dot_run_q, dot_run_d;
    logic [SIZE-1:0][DATA_WIDTH-1:0] dot_data_q, dot_data_d;
    logic [SIZE-1:0][DATA_WIDTH-1:0] dot_weights_q, dot_weights_d;
    logic signed [DATA_WIDTH-1:0]    dot_bias_q, dot_bias_d;
    logic                            out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                            finished_rise;

    mlp_rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .din   (dot_finished),
        .rise  (finished_rise)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bias_d        = bias_q;
        busy_d        = busy_q;
        chunk_req_d   = 1'b0;
        chunk_idx_d   = chunk_idx_q;
        dot_reset_d   = 1'b0;
        dot_run_d     = dot_run_q;
        dot_data_d    = dot_data_q;
        dot_weights_d = dot_weights_q;
        dot_bias_d    = dot_bias_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_CLEAR;
                    bias_d      = bias;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    dot_reset_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Bias rides along with chunk 0 only so it is accumulated once.
                state_d     = ST_FETCH;
                chunk_req_d = 1'b1;
                chunk_idx_d = cnt_q;
                dot_bias_d  = bias_q;
            end
            ST_FETCH: begin
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (chunk_valid) begin
                    state_d       = ST_RUN;
                    dot_data_d    = chunk_data;
                    dot_weights_d = chunk_weights;
                    dot_run_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (finished_rise) begin
                    state_d   = ST_ACCUM;
                    dot_run_d = 1'b0;
                end
            end
            ST_ACCUM: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!dot_finished) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d     = ST_OUTPUT;
                        out_valid_d = 1'b1;
                        out_data_d  = relu_clamp(RELU_EN, dot_result[DATA_WIDTH-1]) ? '0 : dot_result;
                    end else begin
                        state_d     = ST_FETCH;
                        cnt_d       = cnt_q + IDX_W'(1);
                        chunk_req_d = 1'b1;
                        chunk_idx_d = cnt_q + IDX_W'(1);
                        dot_bias_d  = '0;
                    end
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bias_q        <= '0;
            busy_q        <= 1'b0;
            chunk_req_q   <= 1'b0;
            chunk_idx_q   <= '0;
            dot_reset_q   <= 1'b0;
            dot_run_q     <= 1'b0;
            dot_data_q    <= '0;
            dot_weights_q <= '0;
            dot_bias_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bias_q        <= bias_d;
            busy_q        <= busy_d;
            chunk_req_q   <= chunk_req_d;
            chunk_idx_q   <= chunk_idx_d;
            dot_reset_q   <= dot_reset_d;
            dot_run_q     <= dot_run_d;
            dot_data_q    <= dot_data_d;
            dot_weights_q <= dot_weights_d;
            dot_bias_q    <= dot_bias_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign busy        = busy_q;
    assign chunk_req   = chunk_req_q;
    assign chunk_idx   = chunk_idx_q;
    assign dot_reset   = dot_reset_q;
    assign dot_run     = dot_run_q;
    assign dot_data    = dot_data_q;
    assign dot_weights = dot_weights_q;
    assign dot_bias    = dot_bias_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_mlp_dot_sequencer.sv
// Bench for mlp_dot_sequencer: a 3-chunk ReLU build and a 1-chunk linear build,
// each with operand memory, downstream dot stage and consumer models.
module tb_mlp_dot_sequencer;

    localparam int SIZE = 4;
    localparam int DW   = 16;
    localparam int FW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    logic          start_s  [2];
    logic [DW-1:0] bias_s   [2];
    logic [DW-1:0] mem_d    [2][3][SIZE];
    logic [DW-1:0] mem_w    [2][3][SIZE];
    int            mem_dly  [2];
    int            ds_dly   [2];
    int            ready_hold [2];
    bit            spurious [2];
    int            exp_idx  [2];
    int            starts   [2];
    int            done_cnt [2];
    int            dot_reset_cnt [2];
    bit            extra_starts;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-neuron arithmetic straight from the stimulus arrays.
    function automatic logic [DW-1:0] ref_result(input int g, input int nch, input bit relu);
        int acc;
        logic [DW-1:0] r;
        acc = int'($signed(bias_s[g]));
        for (int c = 0; c < nch; c++)
            for (int e = 0; e < SIZE; e++)
                acc += (int'($signed(mem_d[g][c][e])) * int'($signed(mem_w[g][c][e]))) >>> FW;
        r = DW'(acc);
        if (relu && r[DW-1]) r = '0;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NCH  = (g == 0) ? 3 : 1;
        localparam bit RELU = (g == 0);
        localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;

        logic                    busy, chunk_req, chunk_valid, dot_reset, dot_run;
        logic                    dot_finished, out_valid, out_ready;
        logic [IW-1:0]           chunk_idx;
        logic [SIZE-1:0][DW-1:0] chunk_data, chunk_weights, dot_data, dot_weights;
        logic [DW-1:0]           dot_bias, dot_result, out_data;
        int                      acc;

        mlp_dot_sequencer #(
            .SIZE(SIZE), .DATA_WIDTH(DW), .FRACTION_WIDTH(FW),
            .NUM_CHUNKS(NCH), .RELU_EN(RELU)
        ) u_dut (
            .clk(clk), .reset(rst_n), .start(start_s[g]), .busy(busy),
            .chunk_req(chunk_req), .chunk_idx(chunk_idx), .chunk_valid(chunk_valid),
            .chunk_data(chunk_data), .chunk_weights(chunk_weights), .bias(bias_s[g]),
            .dot_reset(dot_reset), .dot_run(dot_run), .dot_data(dot_data),
            .dot_weights(dot_weights), .dot_bias(dot_bias), .dot_finished(dot_finished),
            .dot_result(dot_result), .out_valid(out_valid), .out_ready(out_ready),
            .out_data(out_data)
        );

        // Operand memory: answers each request after mem_dly cycles.
        initial begin
            int idx;
            chunk_valid = 1'b0;
            chunk_data = '0;
            chunk_weights = '0;
            forever begin
                @(posedge clk); #1;
                if (chunk_req) begin
                    check("chunk_idx", 32'(chunk_idx), 32'(exp_idx[g]));
                    exp_idx[g]++;
                    idx = int'(chunk_idx);
                    for (int k = 0; k < mem_dly[g]; k++) begin @(posedge clk); #1; end
                    chunk_valid = 1'b1;
                    for (int e = 0; e < SIZE; e++) begin
                        chunk_data[e]    = mem_d[g][idx][e];
                        chunk_weights[e] = mem_w[g][idx][e];
                    end
                    @(posedge clk); #1;
                    chunk_valid = 1'b0;
                    for (int e = 0; e < SIZE; e++) begin
                        chunk_data[e]    = DW'($urandom);
                        chunk_weights[e] = DW'($urandom);
                    end
                    if (spurious[g]) begin
                        chunk_valid = 1'b1;
                        @(posedge clk); #1;
                        chunk_valid = 1'b0;
                    end
                end
            end
        end

        // Downstream dot stage: accumulates dot(data,weights)+bias ds_dly cycles after run.
        initial begin
            int s;
            dot_finished = 1'b0;
            dot_result = '0;
            acc = 0;
            forever begin
                @(posedge clk); #1;
                if (dot_reset) begin
                    acc = 0;
                    dot_reset_cnt[g]++;
                end
                if (dot_run && !dot_finished) begin
                    for (int k = 1; k < ds_dly[g]; k++) begin @(posedge clk); #1; end
                    s = 0;
                    for (int e = 0; e < SIZE; e++)
                        s += (int'($signed(dot_data[e])) * int'($signed(dot_weights[e]))) >>> FW;
                    acc += s + int'($signed(dot_bias));
                    dot_result = DW'(acc);
                    dot_finished = 1'b1;
                end else if (!dot_run) begin
                    dot_finished = 1'b0;
                end
            end
        end

        // Consumer and scoreboard monitor.
        initial begin
            logic [DW-1:0] held, e;
            int  waitc;
            bit  active, have;
            out_ready = 1'b0;
            active = 1'b0;
            waitc = 0;
            held = '0;
            e = '0;
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    if (!active) begin
                        active = 1'b1;
                        held = out_data;
                        waitc = ready_hold[g];
                        have = 1'b0;
                        if (g == 0) begin
                            if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                        end else begin
                            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                        end
                        if (!have) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_output inst%0d: got %0h expected none", g, out_data);
                        end else begin
                            check($sformatf("out_data_inst%0d", g), 32'(out_data), 32'(e));
                        end
                    end else begin
                        check("out_data_stable", 32'(out_data), 32'(held));
                    end
                    check("busy_during_output", 32'(busy), 1);
                    if (waitc == 0) out_ready = 1'b1;
                    else begin
                        waitc--;
                        out_ready = 1'b0;
                    end
                end else begin
                    if (active) done_cnt[g]++;
                    active = 1'b0;
                    out_ready = ($urandom_range(3) == 0);
                end
            end
        end
    end

    function automatic logic busy_of(input int g);
        return (g == 0) ? g_inst[0].busy : g_inst[1].busy;
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic fill(input int g, input logic [DW-1:0] d, input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int c = 0; c < 3; c++)
            for (int e = 0; e < SIZE; e++) begin
                mem_d[g][c][e] = d;
                mem_w[g][c][e] = w;
            end
        bias_s[g] = b;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},        32'(g_inst[0].busy), 0);
        check({tag, "_chunk_req"},   32'(g_inst[0].chunk_req), 0);
        check({tag, "_chunk_idx"},   32'(g_inst[0].chunk_idx), 0);
        check({tag, "_dot_reset"},   32'(g_inst[0].dot_reset), 0);
        check({tag, "_dot_run"},     32'(g_inst[0].dot_run), 0);
        check({tag, "_dot_data"},    32'(g_inst[0].dot_data == '0), 1);
        check({tag, "_dot_weights"}, 32'(g_inst[0].dot_weights == '0), 1);
        check({tag, "_dot_bias"},    32'(g_inst[0].dot_bias), 0);
        check({tag, "_out_valid"},   32'(g_inst[0].out_valid), 0);
        check({tag, "_out_data"},    32'(g_inst[0].out_data), 0);
    endtask

    task automatic run_eval(input int g, input logic [DW-1:0] expv);
        int n;
        if (g == 0) exp_q0.push_back(expv);
        else        exp_q1.push_back(expv);
        @(negedge clk);
        start_s[g] = 1'b1;
        exp_idx[g] = 0;
        starts[g]++;
        @(negedge clk);
        start_s[g] = 1'b0;
        bias_s[g] = DW'($urandom);
        check("busy_after_start", 32'(busy_of(g)), 1);
        n = 0;
        while (busy_of(g) && n < 2000) begin
            start_s[g] = extra_starts && (n % 6 == 3);
            @(negedge clk);
            n++;
        end
        start_s[g] = 1'b0;
        check("eval_within_budget", 32'(n < 2000), 1);
        @(negedge clk);
        check("outputs_delivered", 32'(done_cnt[g]), 32'(starts[g]));
        check("dot_reset_cycles", 32'(dot_reset_cnt[g]), 32'(starts[g]));
        check("scoreboard_drained", 32'(qsize(g)), 0);
        check("idx_count", 32'(exp_idx[g]), (g == 0) ? 32'd3 : 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        extra_starts = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0;
            mem_dly[g] = 1;
            ds_dly[g] = 1;
            ready_hold[g] = 0;
            spurious[g] = 1'b0;
            exp_idx[g] = 0;
            starts[g] = 0;
            done_cnt[g] = 0;
            dot_reset_cnt[g] = 0;
            fill(g, '0, '0, '0);
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0 x 0.5 over 12 elements + 0.25 bias = 6.25
        fill(0, 16'h0100, 16'h0080, 16'h0040);
        run_eval(0, 16'h0640);

        // Negative sum clamped by ReLU
        fill(0, 16'h0100, 16'hFF00, 16'h0000);
        run_eval(0, 16'h0000);

        // Slow memory, stalled consumer, stray valids and starts
        fill(0, 16'h0100, 16'h0080, 16'h0040);
        mem_dly[0] = 5;
        ready_hold[0] = 10;
        spurious[0] = 1'b1;
        extra_starts = 1'b1;
        run_eval(0, 16'h0640);
        mem_dly[0] = 1;
        ready_hold[0] = 0;
        spurious[0] = 1'b0;
        extra_starts = 1'b0;

        // Reset during RUN of chunk 1, then a clean re-run
        fill(0, 16'h0100, 16'h0080, 16'h0040);
        ds_dly[0] = 8;
        @(negedge clk);
        start_s[0] = 1'b1;
        exp_idx[0] = 0;
        @(negedge clk);
        start_s[0] = 1'b0;
        n = 0;
        while (!(g_inst[0].dot_run && exp_idx[0] == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_run_chunk1", 32'(n < 200), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        dot_reset_cnt[0] = starts[0];
        ds_dly[0] = 1;
        fill(0, 16'h0100, 16'h0080, 16'h0040);
        run_eval(0, 16'h0640);

        // Single-chunk linear build: 2.0 x 2.0 x 4 = 16.0, twice back-to-back
        fill(1, 16'h0200, 16'h0200, 16'h0000);
        run_eval(1, 16'h1000);
        fill(1, 16'h0200, 16'h0200, 16'h0000);
        run_eval(1, 16'h1000);

        // Without ReLU the negative result passes through: -4.0
        fill(1, 16'h0100, 16'hFF00, 16'h0000);
        run_eval(1, 16'hFC00);

        for (int i = 0; i < 14; i++) begin
            int g;
            g = i % 2;
            for (int c = 0; c < 3; c++)
                for (int e = 0; e < SIZE; e++) begin
                    mem_d[g][c][e] = DW'($urandom);
                    mem_w[g][c][e] = DW'($urandom);
                end
            bias_s[g] = DW'($urandom);
            mem_dly[g] = $urandom_range(4, 1);
            ds_dly[g] = $urandom_range(4, 1);
            ready_hold[g] = $urandom_range(3, 0);
            spurious[g] = 1'($urandom_range(1, 0));
            extra_starts = 1'($urandom_range(1, 0));
            run_eval(g, ref_result(g, (g == 0) ? 3 : 1, g == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
